// File: rtl/mc_ctl.sv
// Multi-cycle MIPS main control FSM: decodes the opcode in DECODE and sequences the
// datapath one step per state, stalling on mem_ready in FETCH, MEM_READ and MEM_WRITE.
module mc_ctl #(
  parameter logic [5:0] OP_R   = 6'd0,
  parameter logic [5:0] OP_LW  = 6'd35,
  parameter logic [5:0] OP_SW  = 6'd43,
  parameter logic [5:0] OP_BEQ = 6'd4,
  parameter logic [5:0] OP_J   = 6'd2,
  parameter logic [5:0] OP_ORI = 6'd13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StBeq      = 4'd9,
    StJump     = 4'd10,
    StOriExec  = 4'd11,
    StOriWb    = 4'd12
  } state_e;

  state_e state_q, state_d;
  logic   is_lw_q, is_lw_d;
  logic   op_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_lw_d    = is_lw_q;
    op_illegal = 1'b0;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        // Load/store class is captured here so MEM_ADDR never looks at Op again.
        is_lw_d = (Op == OP_LW);
        if (Op == OP_LW || Op == OP_SW) begin
          state_d = StMemAddr;
        end else if (Op == OP_R) begin
          state_d = StRExec;
        end else if (Op == OP_BEQ) begin
          state_d = StBeq;
        end else if (Op == OP_J) begin
          state_d = StJump;
        end else if (Op == OP_ORI) begin
          state_d = StOriExec;
        end else begin
          state_d    = StFetch;
          op_illegal = 1'b1;
        end
      end
      StMemAddr:  state_d = is_lw_q ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StRExec:    state_d = StRWb;
      StRWb:      state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJump:     state_d = StFetch;
      StOriExec:  state_d = StOriWb;
      StOriWb:    state_d = StFetch;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ZeroExt     = 1'b0;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        ALUSrcB    = 2'b11;
        illegal    = op_illegal;
        instr_done = op_illegal;
      end
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      StRExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StRWb: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      StBeq: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      StJump: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      StOriExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ZeroExt = 1'b1;
        ALUOp   = 2'b11;
      end
      StOriWb: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/mc_ctl.md
Name: mc_ctl

Overview:
- Multi-cycle main control FSM for the MIPS datapath. It decodes the instruction opcode and sequences the datapath one step per state.
- It drives the 2-bit ALUOp that the ALU control unit consumes, along with every mux select and write enable.
- It sits between the instruction register opcode field and the datapath. It stalls on a memory-ready handshake.

Parameters:
- OP_R, 6'd0, R-type opcode (ALUOp=10; Funct resolves add/sub/and/or/slt/srl)
- OP_LW, 6'd35, load word
- OP_SW, 6'd43, store word
- OP_BEQ, 6'd4, branch if equal
- OP_J, 6'd2, jump
- OP_ORI, 6'd13, or-immediate (ALUOp=11)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- Op  in  6  opcode from the instruction register (bits 31:26), sampled in DECODE
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU Zero (datapath ANDs it)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register: 0=rt, 1=rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A: 0=PC, 1=A
- ALUSrcB  out  2  ALU B: 00=B, 01=4, 10=ext imm, 11=sext imm<<2
- ZeroExt  out  1  immediate extension: 1=zero-extend, 0=sign-extend
- ALUOp  out  2  00=add, 01=sub, 10=funct, 11=or
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse when DECODE sees an unknown opcode
- state  out  4  current state encoding (debug)

Behaviour:
- Clocking and reset
  - Single clock. Reset is synchronous and active-low: when rst_n=0 at a rising clk edge, state<=IDLE.
  - Outputs are Moore decodes of state, except where qualified by mem_ready as noted.
  - Reset aborts any state, including mid-wait on memory. No write enable asserts in the cycle after reset.
- Output defaults
  - All outputs not listed for a state are 0.
  - In IDLE every output is 0 and state=0.
- States and transitions
  - IDLE(0): always -> FETCH.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
    - IRWrite=PCWrite=mem_ready.
    - If mem_ready=0, hold in FETCH; the PC and IR do not change. If mem_ready=1 -> DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
    - LW/SW -> MEM_ADDR
    - R -> R_EXEC
    - BEQ -> BEQ
    - J -> JUMP
    - ORI -> ORI_EXEC
    - any other Op -> FETCH, with illegal=1 and instr_done=1 in this cycle
  - MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00, ZeroExt=0. LW -> MEM_READ; SW -> MEM_WRITE.
    - MEM_ADDR latches the opcode class internally at the DECODE exit; it does not resample Op.
  - MEM_READ(4): MemRead=1, IorD=1. Hold until mem_ready=1, then -> MEM_WB.
  - MEM_WB(5): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 -> FETCH.
  - MEM_WRITE(6): MemWrite=1, IorD=1. Hold until mem_ready=1.
    - instr_done=mem_ready; -> FETCH when mem_ready=1.
  - R_EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
  - R_WB(8): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
  - BEQ(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH.
  - JUMP(10): PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
  - ORI_EXEC(11): ALUSrcA=1, ALUSrcB=10, ZeroExt=1, ALUOp=11 -> ORI_WB.
  - ORI_WB(12): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
  - Unused encodings 13-15 -> IDLE next cycle, with all outputs 0.
- Latency with mem_ready tied to 1 (cycles FETCH to last state, inclusive)
  - LW 5; SW 4; R 4; ORI 4; BEQ 3; J 3; illegal 2.
  - Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Handshake
  - MemRead/MemWrite and IorD stay stable for the whole wait.
  - Exactly one of MemRead/MemWrite is ever high.
  - Write enables qualified by mem_ready never pulse early.
- Event rules
  - instr_done and illegal are never high in the same cycle, except for an illegal opcode (both high).
  - Op changes outside DECODE have no effect.

Test Plan:
- rst_n=0 for 2 cycles from an arbitrary state -> state=0, all outputs 0; next cycle FETCH with MemRead=1, ALUSrcB=01, ALUOp=00.
- mem_ready=1, Op=0 (R-type) -> states 1,2,7,8; ALUOp=10 in R_EXEC; RegWrite=1, RegDst=1 in R_WB; instr_done on cycle 4.
- Op=35, mem_ready low 3 cycles in MEM_READ -> MemRead=1, IorD=1 held for 4 cycles; MEM_WB with MemtoReg=1, RegWrite=1; total 8 cycles.
- Op=13 (ORI) -> ORI_EXEC with ALUOp=11, ALUSrcB=10, ZeroExt=1; ORI_WB with RegDst=0, RegWrite=1.
- Op=4 then Op=2 -> BEQ: PCWriteCond=1, ALUOp=01, PCSource=01. JUMP: PCWrite=1, PCSource=10. Each takes 3 cycles.
- Op=6'd63 -> DECODE pulses illegal=1 and instr_done=1, then returns to FETCH. Separately, rst_n=0 mid-MEM_WRITE wait -> MemWrite drops, next state IDLE.
